// File: rtl/hazard_fwd_unit_if.sv
// Decode/execute-side bundle for the hazard/forwarding unit.
// The pipeline drives through master; the unit sits on slave.
interface hazard_fwd_unit_if #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned CNT_W      = 16
);
    localparam int unsigned SELW = $clog2(FWD_STAGES + 1);

    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_src_addr;
    logic [NUM_SRC-1:0]        id_src_used;
    logic [REG_AW-1:0]         id_dst_addr;
    logic                      id_dst_we;
    logic                      id_is_load;
    logic                      flush;
    logic                      stall;
    logic                      bubble;
    logic [NUM_SRC*SELW-1:0]   ex_fwd_sel;
    logic [CNT_W-1:0]          stall_count;

    modport master (
        output id_valid, id_src_addr, id_src_used, id_dst_addr, id_dst_we, id_is_load, flush,
        input  stall, bubble, ex_fwd_sel, stall_count
    );

    modport slave (
        input  id_valid, id_src_addr, id_src_used, id_dst_addr, id_dst_we, id_is_load, flush,
        output stall, bubble, ex_fwd_sel, stall_count
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Load-use stall and operand-forward select generation from a shadow table
// of in-flight destination writes, one entry per forwarding stage past decode.
module hazard_fwd_unit #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned CNT_W      = 16
) (
    input logic              clock,
    input logic              reset,
    hazard_fwd_unit_if.slave hif
);
    localparam int unsigned SELW = $clog2(FWD_STAGES + 1);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              ld;
    } entry_t;

    entry_t                  tbl [1:FWD_STAGES];
    logic [NUM_SRC-1:0]      hazard;
    logic [NUM_SRC*SELW-1:0] sel_nxt;
    logic [NUM_SRC*SELW-1:0] sel_q;
    logic                    bub_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    stall_c;
    logic                    issue;

    // Scan oldest to youngest so the smallest matching tap overwrites older ones.
    always_comb begin
        hazard  = '0;
        sel_nxt = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            for (int unsigned k = FWD_STAGES; k >= 1; k--) begin
                if (hif.id_src_used[i] && hif.id_valid && tbl[k].v &&
                    tbl[k].rd == hif.id_src_addr[i*REG_AW +: REG_AW] &&
                    !(ZERO_REG != 0 && hif.id_src_addr[i*REG_AW +: REG_AW] == '0)) begin
                    sel_nxt[i*SELW +: SELW] = SELW'(k);
                    hazard[i]               = tbl[k].ld && (k <= LOAD_LAT);
                end
            end
        end
    end

    assign stall_c = reset && hif.id_valid && !hif.flush && (|hazard);
    assign issue   = hif.id_valid && !stall_c && !hif.flush;

    // A flushed EX entry is dropped as it moves into tap 2, so it never forwards.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 1; k <= FWD_STAGES; k++) begin
                tbl[k] <= '0;
            end
        end else begin
            tbl[1] <= issue ? entry_t'{v: hif.id_dst_we, rd: hif.id_dst_addr, ld: hif.id_is_load}
                            : entry_t'('0);
            for (int unsigned k = 2; k <= FWD_STAGES; k++) begin
                tbl[k] <= (k == 2 && hif.flush) ? entry_t'('0) : tbl[k-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel_q <= '0;
            bub_q <= 1'b1;
            cnt_q <= '0;
        end else begin
            sel_q <= issue ? sel_nxt : '0;
            bub_q <= !issue;
            if (stall_c && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign hif.stall       = stall_c;
    assign hif.bubble      = bub_q;
    assign hif.ex_fwd_sel  = sel_q;
    assign hif.stall_count = cnt_q;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench: two configurations (LOAD_LAT=1/FWD_STAGES=2 and
// LOAD_LAT=2/FWD_STAGES=3) fed the same decode stream.
module tb_hazard_fwd_unit;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    hazard_fwd_unit_if #(.REG_AW(5), .NUM_SRC(2), .FWD_STAGES(2), .CNT_W(3))  ifa ();
    hazard_fwd_unit_if #(.REG_AW(5), .NUM_SRC(2), .FWD_STAGES(3), .CNT_W(16)) ifb ();

    hazard_fwd_unit #(.REG_AW(5), .NUM_SRC(2), .FWD_STAGES(2), .LOAD_LAT(1), .ZERO_REG(1), .CNT_W(3))
        dut_a (.clock(clock), .reset(reset), .hif(ifa));
    hazard_fwd_unit #(.REG_AW(5), .NUM_SRC(2), .FWD_STAGES(3), .LOAD_LAT(2), .ZERO_REG(1), .CNT_W(16))
        dut_b (.clock(clock), .reset(reset), .hif(ifb));

    // Expected registered outputs packed as {bubble, sel1[1:0], sel0[1:0]}; NC skips a check.
    localparam logic [4:0] NC  = 5'h1F;
    localparam logic [4:0] BUB = 5'h10;

    typedef struct {
        logic [4:0] ea;
        logic [4:0] eb;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            if (mon_e.ea != NC) check("A.bub_sel", {27'd0, ifa.bubble, ifa.ex_fwd_sel}, {27'd0, mon_e.ea});
            if (mon_e.eb != NC) check("B.bub_sel", {27'd0, ifb.bubble, ifb.ex_fwd_sel}, {27'd0, mon_e.eb});
        end
    end

    task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                         input logic [4:0] dst, input logic we, input logic ld, input logic fl);
        ifa.id_valid = v;  ifa.id_src_addr = {s1, s0}; ifa.id_src_used = used;
        ifa.id_dst_addr = dst; ifa.id_dst_we = we; ifa.id_is_load = ld; ifa.flush = fl;
        ifb.id_valid = v;  ifb.id_src_addr = {s1, s0}; ifb.id_src_used = used;
        ifb.id_dst_addr = dst; ifb.id_dst_we = we; ifb.id_is_load = ld; ifb.flush = fl;
    endtask

    // sta/stb < 0 skip the combinational stall check for that configuration.
    task automatic step(input logic v, input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                        input logic [4:0] dst, input logic we, input logic ld, input logic fl,
                        input int sta, input int stb, input logic [4:0] ea, input logic [4:0] eb);
        @(negedge clock);
        drive(v, s0, s1, used, dst, we, ld, fl);
        #1;
        if (sta >= 0) check("A.stall", {31'd0, ifa.stall}, sta);
        if (stb >= 0) check("B.stall", {31'd0, ifb.stall}, stb);
        sb.push_back('{ea, eb});
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, BUB, BUB);
    endtask

    task automatic counts(input string tag, input int ca, input int cb);
        check({tag, ".A.cnt"}, {29'd0, ifa.stall_count}, ca);
        if (cb >= 0) check({tag, ".B.cnt"}, {16'd0, ifb.stall_count}, cb);
    endtask

    initial begin
        drive(1, 5'd3, 5'd3, 2'b11, 5'd4, 1, 1, 0);
        repeat (2) @(negedge clock);
        #1;
        check("rst.A.stall", {31'd0, ifa.stall}, 0);
        check("rst.A.out", {27'd0, ifa.bubble, ifa.ex_fwd_sel}, BUB);
        check("rst.B.out", {27'd0, ifb.bubble, ifb.ex_fwd_sel}, BUB);
        counts("rst", 0, 0);
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;

        // back-to-back ALU dependency, both operands on tap 1
        step(1, 0, 0, 2'b00, 5'd3, 1, 0, 0, 0, 0, 5'h00, 5'h00);
        step(1, 5'd3, 5'd3, 2'b11, 5'd4, 1, 0, 0, 0, 0, 5'h05, 5'h05);
        nops(3);
        // one-instruction gap, tap 2
        step(1, 0, 0, 2'b00, 5'd3, 1, 0, 0, 0, 0, 5'h00, 5'h00);
        nops(1);
        step(1, 5'd3, 5'd2, 2'b11, 5'd5, 1, 0, 0, 0, 0, 5'h02, 5'h02);
        nops(3);
        // youngest writer wins
        step(1, 0, 0, 2'b00, 5'd9, 1, 0, 0, 0, 0, 5'h00, 5'h00);
        step(1, 0, 0, 2'b00, 5'd9, 1, 0, 0, 0, 0, 5'h00, 5'h00);
        step(1, 5'd9, 5'd9, 2'b11, 5'd10, 1, 0, 0, 0, 0, 5'h05, 5'h05);
        nops(3);
        // r0 never matches
        step(1, 0, 0, 2'b00, 5'd0, 1, 0, 0, 0, 0, 5'h00, 5'h00);
        step(1, 5'd0, 5'd0, 2'b11, 5'd11, 1, 0, 0, 0, 0, 5'h00, 5'h00);
        nops(3);
        // load-use: A stalls 1 cycle then tap 2, B stalls 2 cycles then tap 3
        step(1, 0, 0, 2'b00, 5'd7, 1, 1, 0, 0, 0, 5'h00, 5'h00);
        step(1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 0, 1, 1, BUB, BUB);
        step(1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 0, 0, 1, 5'h02, BUB);
        step(1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 0, 0, 0, 5'h00, 5'h03);
        counts("lduse", 1, 2);
        nops(3);
        // operands with different winners, one of them a load-use hazard
        step(1, 0, 0, 2'b00, 5'd2, 1, 0, 0, 0, 0, 5'h00, 5'h00);
        step(1, 0, 0, 2'b00, 5'd7, 1, 1, 0, 0, 0, 5'h00, 5'h00);
        step(1, 5'd2, 5'd7, 2'b11, 5'd9, 1, 0, 0, 1, 1, BUB, BUB);
        step(1, 5'd2, 5'd7, 2'b11, 5'd9, 1, 0, 0, 0, 1, 5'h08, BUB);
        step(1, 5'd2, 5'd7, 2'b11, 5'd9, 1, 0, 0, 0, 0, 5'h00, 5'h0C);
        counts("mixed", 2, 4);
        nops(3);
        // flush kills the stalling load in EX
        step(1, 0, 0, 2'b00, 5'd7, 1, 1, 0, 0, 0, 5'h00, 5'h00);
        step(1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 1, 0, 0, BUB, BUB);
        step(1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 0, 0, 0, 5'h00, 5'h00);
        counts("flush", 2, 4);
        nops(3);
        // reset asserted mid-stall
        step(1, 0, 0, 2'b00, 5'd7, 1, 1, 0, 0, 0, 5'h00, 5'h00);
        @(negedge clock);
        drive(1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 0);
        #1;
        check("pre_rst.A.stall", {31'd0, ifa.stall}, 1);
        check("pre_rst.B.stall", {31'd0, ifb.stall}, 1);
        reset = 1'b0;
        #1;
        check("mid_rst.A.stall", {31'd0, ifa.stall}, 0);
        check("mid_rst.B.stall", {31'd0, ifb.stall}, 0);
        check("mid_rst.A.out", {27'd0, ifa.bubble, ifa.ex_fwd_sel}, BUB);
        check("mid_rst.B.out", {27'd0, ifb.bubble, ifb.ex_fwd_sel}, BUB);
        counts("mid_rst", 0, 0);
        @(negedge clock);
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
        reset = 1'b1;
        nops(1);
        // saturation of the 3-bit counter in configuration A
        for (int n = 1; n <= 8; n++) begin
            step(1, 0, 0, 2'b00, 5'd7, 1, 1, 0, 0, -1, 5'h00, NC);
            step(1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 0, 1, -1, BUB, NC);
            step(1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 0, 0, -1, 5'h02, NC);
            counts("sat", (n > 7) ? 7 : n, -1);
        end
        @(posedge clock);
        #2;
        if (sb.size() != 0) check("sb.drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
